// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: write-back select codes, register constants and commit record shared by the WB stage.
package wb_regfile_pkg;

    typedef enum logic [7:0] {
        WB_ALU     = 8'h00,
        WB_MEMW    = 8'h01,
        WB_MEMB    = 8'h02,
        WB_MEMBU   = 8'h03,
        WB_MEMH    = 8'h04,
        WB_MEMHU   = 8'h05,
        WB_PC8     = 8'h06,
        WB_IMM     = 8'h07,
        WB_INITIAL = 8'hFF
    } wb_sel_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  a3;
        logic [31:0] wd;
    } commit_t;

    // Extends the low byte (half_i=0) or the full halfword (half_i=1) of lane_i.
    function automatic logic [31:0] ext_lane(input logic [15:0] lane_i, input logic half_i, input logic sgn_i);
        return half_i ? {{16{sgn_i & lane_i[15]}}, lane_i} : {{24{sgn_i & lane_i[7]}}, lane_i[7:0]};
    endfunction

endpackage

// File: rtl/wb_data_ext.sv
// wb_data_ext: combinational load extender selecting the addressed byte/half of an aligned read word.
module wb_data_ext
    import wb_regfile_pkg::*;
(
    input  logic [31:0] rd_i,
    input  logic [1:0]  off_i,
    input  logic [7:0]  code_i,
    output logic [31:0] data_o
);

    logic [15:0] byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = {8'h00, 8'(rd_i >> {off_i, 3'b000})};
        half_lane = off_i[1] ? rd_i[31:16] : rd_i[15:0];
        data_o    = code_i == WB_MEMB  ? ext_lane(byte_lane, 1'b0, 1'b1) :
                    code_i == WB_MEMBU ? ext_lane(byte_lane, 1'b0, 1'b0) :
                    code_i == WB_MEMH  ? ext_lane(half_lane, 1'b1, 1'b1) :
                    code_i == WB_MEMHU ? ext_lane(half_lane, 1'b1, 1'b0) : '0;
    end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage with the GPR file, bypassed D-stage reads, commit trace,
// retired-instruction counter and sticky Tnew error flag.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int          DATA_W       = 32,
    parameter int          NREG         = 32,
    parameter bit          TRACE_EN     = 1'b1,
    parameter logic [31:0] INSTRET_INIT = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        w_a3,
    input  logic [DATA_W-1:0] w_aluout,
    input  logic [DATA_W-1:0] w_rd,
    input  logic [31:0]       w_pc,
    input  logic [31:0]       w_pc8,
    input  logic              w_wegrf,
    input  logic [7:0]        w_whichtoreg,
    input  logic [DATA_W-1:0] w_imm32,
    input  logic [1:0]        w_tnew,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              wb_we,
    output logic [4:0]        wb_a3,
    output logic [DATA_W-1:0] wb_wd,
    output logic              commit_valid,
    output logic [31:0]       commit_pc,
    output logic [4:0]        commit_a3,
    output logic [DATA_W-1:0] commit_wd,
    output logic [31:0]       instret,
    output logic              tnew_err
);

    logic [DATA_W-1:0] ext_wd;
    logic [DATA_W-1:0] gpr_q [NREG];
    commit_t           commit_q, commit_d;
    logic [31:0]       instret_q, instret_d;
    logic              tnew_err_q, tnew_err_d;
    logic              retire;
    logic              trace_load;

    wb_data_ext u_ext (
        .rd_i   (w_rd),
        .off_i  (w_aluout[1:0]),
        .code_i (w_whichtoreg),
        .data_o (ext_wd)
    );

    always_comb begin
        wb_wd = w_whichtoreg == WB_ALU  ? w_aluout :
                w_whichtoreg == WB_MEMW ? w_rd     :
                w_whichtoreg == WB_PC8  ? w_pc8    :
                w_whichtoreg == WB_IMM  ? w_imm32  : ext_wd;
    end

    assign wb_we      = w_wegrf && w_a3 != REG_ZERO;
    assign wb_a3      = w_a3;
    assign retire     = w_pc != 32'h0;
    assign trace_load = wb_we && TRACE_EN;

    // The in-flight write is forwarded so a D-stage read sees it in the same cycle.
    assign rs_data = rs_addr == REG_ZERO ? '0 : (wb_we && rs_addr == w_a3) ? wb_wd : gpr_q[rs_addr];
    assign rt_data = rt_addr == REG_ZERO ? '0 : (wb_we && rt_addr == w_a3) ? wb_wd : gpr_q[rt_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
        end else if (wb_we) begin
            gpr_q[w_a3] <= wb_wd;
        end
    end

    // Trace fields other than valid hold their last committed values between commits.
    always_comb begin
        commit_d       = commit_q;
        commit_d.valid = trace_load;
        if (trace_load) begin
            commit_d.pc = w_pc;
            commit_d.a3 = w_a3;
            commit_d.wd = wb_wd;
        end
        instret_d  = instret_q + 32'(retire);
        tnew_err_d = tnew_err_q || (retire && w_tnew != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            commit_q   <= '0;
            instret_q  <= INSTRET_INIT;
            tnew_err_q <= 1'b0;
        end else begin
            commit_q   <= commit_d;
            instret_q  <= instret_d;
            tnew_err_q <= tnew_err_d;
        end
    end

    assign commit_valid = commit_q.valid;
    assign commit_pc    = commit_q.pc;
    assign commit_a3    = commit_q.a3;
    assign commit_wd    = commit_q.wd;
    assign instret      = instret_q;
    assign tnew_err     = tnew_err_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: table-driven bench for wb_regfile with a commit-trace scoreboard and a GPR model.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [7:0]  sel;
        logic [31:0] alu;
        logic [31:0] rd;
        logic [31:0] pc;
        logic [31:0] pc8;
        logic [31:0] imm;
        logic [1:0]  tnew;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] wd;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  a3;
        logic [31:0] wd;
    } cm_t;

    logic clk = 1'b0, reset = 1'b0;
    logic [4:0]  w_a3 = '0, rs_addr = '0, rt_addr = '0;
    logic [31:0] w_aluout = '0, w_rd = '0, w_pc = '0, w_pc8 = '0, w_imm32 = '0;
    logic        w_wegrf = 1'b0;
    logic [7:0]  w_whichtoreg = '0;
    logic [1:0]  w_tnew = '0;
    logic [31:0] rs_data, rt_data, wb_wd, commit_pc, commit_wd, instret;
    logic        wb_we, commit_valid, tnew_err;
    logic [4:0]  wb_a3, commit_a3;
    logic [31:0] x_rs, x_rt, x_wd, x_cpc, x_cwd, wrap_instret;
    logic        x_we, x_cv, x_te;
    logic [4:0]  x_a3, x_ca3;

    int checks = 0, errors = 0;
    logic [31:0] model [32];
    logic [31:0] exp_ir, exp_wrap;
    logic        exp_tnew;
    cm_t         last, sbq[$];
    vec_t        vt[$];

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .reset(reset), .w_a3(w_a3), .w_aluout(w_aluout), .w_rd(w_rd), .w_pc(w_pc),
        .w_pc8(w_pc8), .w_wegrf(w_wegrf), .w_whichtoreg(w_whichtoreg), .w_imm32(w_imm32),
        .w_tnew(w_tnew), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_a3(commit_a3), .commit_wd(commit_wd),
        .instret(instret), .tnew_err(tnew_err)
    );

    // Second instance starts its counter just below the wrap point.
    wb_regfile #(.INSTRET_INIT(32'hFFFF_FFFE)) u_wrap (
        .clk(clk), .reset(reset), .w_a3(w_a3), .w_aluout(w_aluout), .w_rd(w_rd), .w_pc(w_pc),
        .w_pc8(w_pc8), .w_wegrf(w_wegrf), .w_whichtoreg(w_whichtoreg), .w_imm32(w_imm32),
        .w_tnew(w_tnew), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(x_rs), .rt_data(x_rt),
        .wb_we(x_we), .wb_a3(x_a3), .wb_wd(x_wd), .commit_valid(x_cv),
        .commit_pc(x_cpc), .commit_a3(x_ca3), .commit_wd(x_cwd),
        .instret(wrap_instret), .tnew_err(x_te)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a, input logic we, input logic [4:0] a3,
                                          input logic [31:0] wd);
        return a == 5'd0 ? 32'h0 : (we && a == a3) ? wd : model[a];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        exp_ir = '0;
        exp_wrap = 32'hFFFF_FFFE;
        exp_tnew = 1'b0;
        last = '{1'b0, 32'h0, 5'd0, 32'h0};
    endtask

    task automatic check_commit();
        cm_t c;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty");
        end else begin
            c = sbq.pop_front();
            chk("commit_valid", {31'h0, commit_valid}, {31'h0, c.v});
            chk("commit_pc", commit_pc, c.pc);
            chk("commit_a3", {27'h0, commit_a3}, {27'h0, c.a3});
            chk("commit_wd", commit_wd, c.wd);
        end
    endtask

    task automatic apply(input vec_t v);
        logic we_e;
        cm_t  c;
        @(negedge clk);
        w_wegrf = v.we; w_a3 = v.a3; w_whichtoreg = v.sel; w_aluout = v.alu; w_rd = v.rd;
        w_pc = v.pc; w_pc8 = v.pc8; w_imm32 = v.imm; w_tnew = v.tnew; rs_addr = v.rs; rt_addr = v.rt;
        #1;
        we_e = v.we && v.a3 != 5'd0;
        chk("wb_wd", wb_wd, v.wd);
        chk("wb_we", {31'h0, wb_we}, {31'h0, we_e});
        chk("wb_a3", {27'h0, wb_a3}, {27'h0, v.a3});
        chk("rs_data", rs_data, mread(v.rs, we_e, v.a3, v.wd));
        chk("rt_data", rt_data, mread(v.rt, we_e, v.a3, v.wd));
        c = we_e ? '{1'b1, v.pc, v.a3, v.wd} : '{1'b0, last.pc, last.a3, last.wd};
        sbq.push_back(c);
        @(posedge clk);
        #1;
        if (we_e) model[v.a3] = v.wd;
        last = c;
        if (v.pc != 32'h0) begin
            exp_ir++;
            exp_wrap++;
        end
        if (v.pc != 32'h0 && v.tnew != 2'd0) exp_tnew = 1'b1;
        check_commit();
        chk("instret", instret, exp_ir);
        chk("instret_wrap", wrap_instret, exp_wrap);
        chk("tnew_err", {31'h0, tnew_err}, {31'h0, exp_tnew});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vt.push_back('{1'b1, 5'd5,  WB_ALU,   32'h1234, 32'h0,        32'h1000, 32'h1008, 32'h0,        2'd0, 5'd5,  5'd0,  32'h0000_1234});
        vt.push_back('{1'b1, 5'd6,  WB_MEMB,  32'h3,    32'h80FF7F01, 32'h1004, 32'h100C, 32'h0,        2'd0, 5'd5,  5'd6,  32'hFFFF_FF80});
        vt.push_back('{1'b1, 5'd7,  WB_MEMBU, 32'h3,    32'h80FF7F01, 32'h1008, 32'h1010, 32'h0,        2'd0, 5'd6,  5'd7,  32'h0000_0080});
        vt.push_back('{1'b1, 5'd8,  WB_MEMH,  32'h2,    32'h80FF7F01, 32'h100C, 32'h1014, 32'h0,        2'd0, 5'd7,  5'd8,  32'hFFFF_80FF});
        vt.push_back('{1'b1, 5'd9,  WB_MEMHU, 32'h2,    32'h80FF7F01, 32'h1010, 32'h1018, 32'h0,        2'd0, 5'd8,  5'd9,  32'h0000_80FF});
        vt.push_back('{1'b1, 5'd10, WB_MEMH,  32'h3,    32'h80FF7F01, 32'h1014, 32'h101C, 32'h0,        2'd0, 5'd9,  5'd10, 32'hFFFF_80FF});
        vt.push_back('{1'b1, 5'd11, WB_MEMB,  32'h0,    32'h80FF7F01, 32'h1018, 32'h1020, 32'h0,        2'd0, 5'd10, 5'd11, 32'h0000_0001});
        vt.push_back('{1'b1, 5'd12, WB_MEMW,  32'h0,    32'h80FF7F01, 32'h101C, 32'h1024, 32'h0,        2'd0, 5'd11, 5'd12, 32'h80FF_7F01});
        vt.push_back('{1'b1, 5'd31, WB_PC8,   32'h0,    32'h0,        32'h1020, 32'h1028, 32'h0,        2'd0, 5'd12, 5'd31, 32'h0000_1028});
        vt.push_back('{1'b1, 5'd13, WB_IMM,   32'h0,    32'h0,        32'h1024, 32'h102C, 32'hABCD0000, 2'd0, 5'd31, 5'd13, 32'hABCD_0000});
        vt.push_back('{1'b1, 5'd14, 8'hFF,    32'h55,   32'h80FF7F01, 32'h1028, 32'h1030, 32'h0,        2'd0, 5'd13, 5'd14, 32'h0000_0000});
        vt.push_back('{1'b1, 5'd15, 8'h09,    32'h55,   32'h80FF7F01, 32'h102C, 32'h1034, 32'h0,        2'd0, 5'd14, 5'd15, 32'h0000_0000});
        vt.push_back('{1'b1, 5'd0,  WB_ALU,   32'hDEAD, 32'h0,        32'h1030, 32'h1038, 32'h0,        2'd0, 5'd0,  5'd0,  32'h0000_DEAD});
        vt.push_back('{1'b0, 5'd5,  WB_ALU,   32'h5555, 32'h0,        32'h1034, 32'h103C, 32'h0,        2'd0, 5'd5,  5'd6,  32'h0000_5555});
        vt.push_back('{1'b0, 5'd0,  WB_ALU,   32'h0,    32'h0,        32'h0,    32'h0,    32'h0,        2'd1, 5'd5,  5'd13, 32'h0000_0000});
        vt.push_back('{1'b1, 5'd16, WB_ALU,   32'h77,   32'h0,        32'h0,    32'h0,    32'h0,        2'd0, 5'd16, 5'd12, 32'h0000_0077});
        vt.push_back('{1'b0, 5'd0,  WB_ALU,   32'h0,    32'h0,        32'h3000, 32'h3008, 32'h0,        2'd1, 5'd16, 5'd31, 32'h0000_0000});
        vt.push_back('{1'b0, 5'd0,  WB_ALU,   32'h0,    32'h0,        32'h3004, 32'h300C, 32'h0,        2'd0, 5'd1,  5'd2,  32'h0000_0000});

        do_reset();
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(31 - a);
            #1;
            chk("reset_rs", rs_data, 32'h0);
            chk("reset_rt", rt_data, 32'h0);
        end
        chk("reset_instret", instret, 32'h0);
        chk("reset_commit_valid", {31'h0, commit_valid}, 32'h0);
        chk("reset_commit_pc", commit_pc, 32'h0);
        chk("reset_tnew_err", {31'h0, tnew_err}, 32'h0);

        foreach (vt[i]) apply(vt[i]);

        // An in-flight write on the reset edge must be discarded.
        @(negedge clk);
        w_wegrf = 1'b1; w_a3 = 5'd5; w_whichtoreg = WB_ALU; w_aluout = 32'h9999; w_pc = 32'h4000;
        w_tnew = 2'd1;
        do_reset();
        w_wegrf = 1'b0; w_pc = 32'h0; w_tnew = 2'd0; rs_addr = 5'd5; rt_addr = 5'd16;
        #1;
        chk("rst_mid_rs", rs_data, 32'h0);
        chk("rst_mid_rt", rt_data, 32'h0);
        chk("rst_mid_instret", instret, 32'h0);
        chk("rst_mid_commit_valid", {31'h0, commit_valid}, 32'h0);
        chk("rst_mid_tnew_err", {31'h0, tnew_err}, 32'h0);
        chk("rst_mid_wrap", wrap_instret, 32'hFFFF_FFFE);

        apply('{1'b1, 5'd3, WB_ALU, 32'hCAFE, 32'h0, 32'h5000, 32'h5008, 32'h0, 2'd0, 5'd3, 5'd5, 32'h0000_CAFE});
        apply('{1'b0, 5'd0, WB_ALU, 32'h0,    32'h0, 32'h5004, 32'h500C, 32'h0, 2'd0, 5'd3, 5'd0, 32'h0000_0000});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
